// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename state (busy bit + ROB tag).
// Reads are combinational with commit bypass; rename/commit/flush update state on clk.
module regfile_rename #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  rn_en,
    input  logic [AW-1:0]         rn_addr,
    input  logic [TAG_W-1:0]      rn_tag,
    input  logic                  cm_en,
    input  logic [AW-1:0]         cm_addr,
    input  logic [TAG_W-1:0]      cm_tag,
    input  logic [XLEN-1:0]       cm_data,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    output logic [NRD*TAG_W-1:0]  rd_tag,
    output logic [AW:0]           busy_cnt
);

    logic [XLEN-1:0]  regs [NREG];
    logic [TAG_W-1:0] tag  [NREG];
    logic [NREG-1:0]  busy;

    logic cm_valid;
    logic rn_valid;

    assign cm_valid = cm_en && (cm_addr != '0);
    assign rn_valid = rn_en && (rn_addr != '0) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                tag[i]  <= '0;
            end
        end else begin
            if (cm_valid) begin
                regs[cm_addr] <= cm_data;
            end
            if (flush) begin
                busy <= '0;
                for (int unsigned i = 0; i < NREG; i++) begin
                    tag[i] <= '0;
                end
            end else begin
                if (cm_valid && busy[cm_addr] && (tag[cm_addr] == cm_tag)) begin
                    busy[cm_addr] <= 1'b0;
                    tag[cm_addr]  <= '0;
                end
                // Placed after the commit clear so a same-register rename overrides it.
                if (rn_valid) begin
                    busy[rn_addr] <= 1'b1;
                    tag[rn_addr]  <= rn_tag;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_tag  = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (!rst && rd_en[i] && (rd_addr[i*AW +: AW] != '0)) begin
                // Commit bypass: value and busy/tag as they will look after this commit.
                if (cm_en && (cm_addr == rd_addr[i*AW +: AW])) begin
                    rd_data[i*XLEN +: XLEN] = cm_data;
                    rd_busy[i] = busy[rd_addr[i*AW +: AW]] &&
                                 (tag[rd_addr[i*AW +: AW]] != cm_tag);
                end else begin
                    rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
                    rd_busy[i] = busy[rd_addr[i*AW +: AW]];
                end
                if (rd_busy[i]) begin
                    rd_tag[i*TAG_W +: TAG_W] = tag[rd_addr[i*AW +: AW]];
                end
            end
        end
    end

    always_comb begin
        busy_cnt = '0;
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                busy_cnt = busy_cnt + {{AW{1'b0}}, busy[i]};
            end
        end
    end

endmodule

// File: tb/tb_regfile_rename.sv
// Directed self-checking bench for regfile_rename: reset, bypass, rename/commit
// interactions, stale-tag commits, flush and x0 handling.
module tb_regfile_rename;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 4;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic                 rn_en;
    logic [AW-1:0]        rn_addr;
    logic [TAG_W-1:0]     rn_tag;
    logic                 cm_en;
    logic [AW-1:0]        cm_addr;
    logic [TAG_W-1:0]     cm_tag;
    logic [XLEN-1:0]      cm_data;
    logic [NRD-1:0]       rd_en;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NRD*TAG_W-1:0] rd_tag;
    logic [AW:0]          busy_cnt;

    int errors = 0;
    int checks = 0;

    regfile_rename #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rn_en(rn_en), .rn_addr(rn_addr), .rn_tag(rn_tag),
        .cm_en(cm_en), .cm_addr(cm_addr), .cm_tag(cm_tag), .cm_data(cm_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .rd_tag(rd_tag), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Check port p against expected data/busy/tag.
    task automatic chk_port(input string name, input int p, input logic [XLEN-1:0] d,
                            input logic b, input logic [TAG_W-1:0] t);
        chk({name, "_data"}, 64'(rd_data[p*XLEN +: XLEN]), 64'(d));
        chk({name, "_busy"}, 64'(rd_busy[p]), 64'(b));
        chk({name, "_tag"},  64'(rd_tag[p*TAG_W +: TAG_W]), 64'(t));
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        flush = 1'b0; rn_en = 1'b0; cm_en = 1'b0;
        rn_addr = '0; rn_tag = '0; cm_addr = '0; cm_tag = '0; cm_data = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        rd_en = 2'b11;
        set_rd(5'd5, 5'd7);
        tick();
        tick();
        // Outputs held at zero while reset is asserted.
        chk_port("rst_p0", 0, 32'h0, 1'b0, 4'h0);
        chk("rst_cnt", 64'(busy_cnt), 64'd0);
        rst = 1'b0;
        #1;

        // 1: all registers empty after reset.
        for (int a = 0; a < NREG; a++) begin
            set_rd(AW'(a), AW'(a));
            #1;
            chk_port($sformatf("init_x%0d_p0", a), 0, 32'h0, 1'b0, 4'h0);
            chk_port($sformatf("init_x%0d_p1", a), 1, 32'h0, 1'b0, 4'h0);
        end
        chk("init_cnt", 64'(busy_cnt), 64'd0);

        // 2: commit with same-cycle bypass.
        cm_en = 1'b1; cm_addr = 5'd5; cm_tag = 4'd0; cm_data = 32'hDEADBEEF;
        set_rd(5'd5, 5'd6);
        #1;
        chk_port("byp_p0", 0, 32'hDEADBEEF, 1'b0, 4'h0);
        chk_port("byp_p1", 1, 32'h0, 1'b0, 4'h0);
        tick();
        idle();
        #1;
        chk_port("stored_x5", 0, 32'hDEADBEEF, 1'b0, 4'h0);
        rd_en = 2'b10;
        #1;
        chk_port("rd_en0_x5", 0, 32'h0, 1'b0, 4'h0);
        rd_en = 2'b11;

        // 3: rename then matching commit.
        rn_en = 1'b1; rn_addr = 5'd7; rn_tag = 4'd3;
        set_rd(5'd7, 5'd5);
        #1;
        chk_port("rn_same_cycle", 0, 32'h0, 1'b0, 4'h0);
        tick();
        idle();
        #1;
        chk_port("rn_x7", 0, 32'h0, 1'b1, 4'd3);
        chk("rn_cnt1", 64'(busy_cnt), 64'd1);
        cm_en = 1'b1; cm_addr = 5'd7; cm_tag = 4'd3; cm_data = 32'h55;
        #1;
        chk_port("cm_byp_x7", 0, 32'h55, 1'b0, 4'h0);
        tick();
        idle();
        #1;
        chk_port("cm_x7", 0, 32'h55, 1'b0, 4'h0);
        chk("cm_cnt0", 64'(busy_cnt), 64'd0);

        // 4: stale-tag commit keeps the newer rename.
        rn_en = 1'b1; rn_addr = 5'd7; rn_tag = 4'd3;
        tick();
        rn_tag = 4'd9;
        tick();
        idle();
        cm_en = 1'b1; cm_addr = 5'd7; cm_tag = 4'd3; cm_data = 32'h11;
        #1;
        chk_port("stale_byp", 0, 32'h11, 1'b1, 4'd9);
        tick();
        idle();
        #1;
        chk_port("stale_x7", 0, 32'h11, 1'b1, 4'd9);
        chk("stale_cnt", 64'(busy_cnt), 64'd1);
        cm_en = 1'b1; cm_addr = 5'd7; cm_tag = 4'd9; cm_data = 32'h11;
        tick();
        idle();
        #1;
        chk("x7_done_cnt", 64'(busy_cnt), 64'd0);

        // 5: rename and matching commit to the same register in one cycle.
        rn_en = 1'b1; rn_addr = 5'd9; rn_tag = 4'd1;
        tick();
        rn_tag = 4'd2;
        cm_en = 1'b1; cm_addr = 5'd9; cm_tag = 4'd1; cm_data = 32'hA5A5;
        set_rd(5'd9, 5'd0);
        #1;
        chk_port("rncm_byp", 0, 32'hA5A5, 1'b0, 4'h0);
        tick();
        idle();
        #1;
        chk_port("rncm_x9", 0, 32'hA5A5, 1'b1, 4'd2);
        chk("rncm_cnt", 64'(busy_cnt), 64'd1);
        cm_en = 1'b1; cm_addr = 5'd9; cm_tag = 4'd2; cm_data = 32'hA5A5;
        tick();
        idle();

        // 6: flush with same-cycle rename and commit.
        for (int r = 1; r <= 3; r++) begin
            rn_en = 1'b1; rn_addr = AW'(r); rn_tag = TAG_W'(r);
            tick();
        end
        idle();
        #1;
        chk("pre_flush_cnt", 64'(busy_cnt), 64'd3);
        flush = 1'b1;
        rn_en = 1'b1; rn_addr = 5'd4; rn_tag = 4'd5;
        cm_en = 1'b1; cm_addr = 5'd2; cm_tag = 4'd2; cm_data = 32'h7;
        tick();
        idle();
        set_rd(5'd4, 5'd2);
        #1;
        chk("flush_cnt", 64'(busy_cnt), 64'd0);
        chk_port("flush_x4", 0, 32'h0, 1'b0, 4'h0);
        chk_port("flush_x2", 1, 32'h7, 1'b0, 4'h0);
        set_rd(5'd1, 5'd3);
        #1;
        chk_port("flush_x1", 0, 32'h0, 1'b0, 4'h0);
        chk_port("flush_x3", 1, 32'h0, 1'b0, 4'h0);

        // x0 writes and renames are ignored, including the bypass path.
        rn_en = 1'b1; rn_addr = 5'd0; rn_tag = 4'd6;
        cm_en = 1'b1; cm_addr = 5'd0; cm_tag = 4'd6; cm_data = 32'hFFFF_FFFF;
        set_rd(5'd0, 5'd0);
        #1;
        chk_port("x0_byp", 0, 32'h0, 1'b0, 4'h0);
        tick();
        idle();
        #1;
        chk_port("x0_after", 1, 32'h0, 1'b0, 4'h0);
        chk("x0_cnt", 64'(busy_cnt), 64'd0);

        // Mid-run reset clears live rename state.
        rn_en = 1'b1; rn_addr = 5'd12; rn_tag = 4'd4;
        tick();
        idle();
        set_rd(5'd12, 5'd5);
        #1;
        chk_port("pre_rst_x12", 0, 32'h0, 1'b1, 4'd4);
        rst = 1'b1;
        #1;
        chk("in_rst_cnt", 64'(busy_cnt), 64'd0);
        chk_port("in_rst_x12", 0, 32'h0, 1'b0, 4'h0);
        tick();
        rst = 1'b0;
        #1;
        chk_port("post_rst_x12", 0, 32'h0, 1'b0, 4'h0);
        chk_port("post_rst_x5", 1, 32'h0, 1'b0, 4'h0);
        chk("post_rst_cnt", 64'(busy_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
